// File: rtl/rose_req_arbiter.sv
// rose_req_arbiter
//   Round-robin ownership arbiter with a fixed acceptance-to-grant latency.
//   A request is accepted in IDLE (one-cycle acc pulse), the grant rises LAT
//   edges after the acceptance edge, is held while the winner keeps its
//   request high, and is followed by one mandatory GAP cycle before the next
//   arbitration. Non-winner requests are ignored until the FSM returns to IDLE.
//
//   Handshake: req[i] is a level request held by requester i. acc[i] pulses
//   for one cycle when i is accepted. gnt[i] then rises and stays high until
//   the first edge that samples req[i] low. Acceptance is committed, so a
//   dropped request still receives at least one grant cycle.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   LAT       edges from the acceptance edge to the first edge sampling gnt high (2..15)
// Ports
//   clk       clock, all state changes on posedge
//   rst       synchronous active-high reset
//   req       per-requester level requests
//   gnt       registered one-hot-or-zero grant
//   acc       registered one-hot one-cycle acceptance pulse
//   busy      high whenever the FSM is not in IDLE
//   dbg_state current FSM state (IDLE=0, WAIT=1, GRANT=2, GAP=3)
//
// Optional: define ROSE_ARB_ASSERT_EN to compile in concurrent assertions.

module rose_req_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] acc,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GRANT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [PW-1:0]   win, win_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [NREQ-1:0] gnt_d, acc_d;

  logic            rr_found;
  logic [PW-1:0]   rr_win;

  // Round-robin search: starts one past the last owner and wraps, so the
  // last owner is considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int j = 1; j <= NREQ; j++) begin
      if (!rr_found && req[(int'(ptr) + j) % NREQ]) begin
        rr_found = 1'b1;
        rr_win   = PW'((int'(ptr) + j) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    win_d   = win;
    ptr_d   = ptr;
    gnt_d   = gnt;
    acc_d   = '0;
    case (state)
      S_IDLE: begin
        if (rr_found) begin
          win_d         = rr_win;
          cnt_d         = 4'(LAT - 2);
          acc_d[rr_win] = 1'b1;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        // The grant register is loaded at the edge where the counter reads 0,
        // so it is first sampled high one edge later (acceptance edge + LAT).
        if (cnt == 4'd0) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          state_d    = S_GRANT;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_GRANT: begin
        if (!req[win]) begin
          gnt_d   = '0;
          ptr_d   = win;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      win   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      win   <= win_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      acc   <= acc_d;
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

`ifdef ROSE_ARB_ASSERT_EN
  // acc is registered, so it is first sampled one edge after the acceptance
  // edge; the grant rise is therefore LAT-1 sampled edges after acc.
  for (genvar i = 0; i < NREQ; i++) begin : g_req_props
    a_acc_to_gnt: assert property (@(posedge clk) disable iff (rst)
      acc[i] |-> ##(LAT-1) $rose(gnt[i]));
    a_gnt_busy: assert property (@(posedge clk) disable iff (rst)
      gnt[i] |-> busy);
  end
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_acc_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(acc));
`endif

endmodule

// File: tb/tb_rose_req_arbiter.sv
// Directed bench for rose_req_arbiter: instance a (NREQ=2, LAT=2) and
// instance b (NREQ=3, LAT=3) share one clock. Inputs change and outputs are
// checked 1 ns after each rising edge.

module tb_rose_req_arbiter;

  logic       clk;
  logic       a_rst, b_rst;
  logic [1:0] a_req, a_gnt, a_acc, a_st;
  logic       a_busy;
  logic [2:0] b_req, b_gnt, b_acc;
  logic [1:0] b_st;
  logic       b_busy;

  int n_pass = 0;
  int n_total = 0;

  rose_req_arbiter #(.NREQ(2), .LAT(2)) dut_a (
    .clk(clk), .rst(a_rst), .req(a_req), .gnt(a_gnt), .acc(a_acc),
    .busy(a_busy), .dbg_state(a_st)
  );

  rose_req_arbiter #(.NREQ(3), .LAT(3)) dut_b (
    .clk(clk), .rst(b_rst), .req(b_req), .gnt(b_gnt), .acc(b_acc),
    .busy(b_busy), .dbg_state(b_st)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full ownership cycle on instance a, starting in IDLE with a_req=11.
  task automatic a_owner(input logic [1:0] w);
    step(); check("a_own_acc", 8'(a_acc), 8'(w)); check("a_own_wait_gnt", 8'(a_gnt), 8'h0);
    step(); check("a_own_gnt", 8'(a_gnt), 8'(w)); check("a_own_acc_clr", 8'(a_acc), 8'h0);
    step(); check("a_own_gnt_hold", 8'(a_gnt), 8'(w));
    a_req = 2'b11 & ~w;
    step(); check("a_own_gap_gnt", 8'(a_gnt), 8'h0); check("a_own_gap_st", 8'(a_st), 8'h3);
    a_req = 2'b11;
    step(); check("a_own_idle_gnt", 8'(a_gnt), 8'h0); check("a_own_idle_busy", 8'(a_busy), 8'h0);
  endtask

  // One full ownership cycle on instance b (LAT=3), starting in IDLE.
  task automatic b_owner(input logic [2:0] r, input logic [2:0] w);
    b_req = r;
    step(); check("b_own_acc", 8'(b_acc), 8'(w));
    step(); check("b_own_wait", 8'(b_gnt), 8'h0);
    step(); check("b_own_gnt", 8'(b_gnt), 8'(w));
    b_req = r & ~w;
    step(); check("b_own_gap", 8'(b_gnt), 8'h0);
    b_req = 3'b000;
    step(); check("b_own_idle", 8'(b_busy), 8'h0);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_req = '0; b_req = '0;
    step(); step();
    check("rst_a_gnt", 8'(a_gnt), 8'h0);
    check("rst_a_acc", 8'(a_acc), 8'h0);
    check("rst_a_busy", 8'(a_busy), 8'h0);
    check("rst_b_gnt", 8'(b_gnt), 8'h0);
    a_rst = 1'b0; b_rst = 1'b0;
    step(); check("idle_no_req", 8'(a_busy), 8'h0);

    // single request on a: acceptance edge E
    a_req = 2'b01;
    step(); check("e_acc", 8'(a_acc), 8'h1); check("e_gnt0", 8'(a_gnt), 8'h0);
    check("e_busy", 8'(a_busy), 8'h1); check("e_st_wait", 8'(a_st), 8'h1);
    step(); check("e1_gnt", 8'(a_gnt), 8'h1); check("e1_acc", 8'(a_acc), 8'h0);
    a_req = 2'b00;
    step(); check("e2_gap_gnt", 8'(a_gnt), 8'h0); check("e2_gap_busy", 8'(a_busy), 8'h1);
    step(); check("e3_idle_busy", 8'(a_busy), 8'h0);

    // both requesting: pointer is 0, so owners alternate 10, 01, 10
    a_req = 2'b11;
    a_owner(2'b10);
    a_owner(2'b01);
    a_owner(2'b10);

    // reset one edge after acceptance abandons the transaction
    a_req = 2'b01;
    step(); check("r_acc", 8'(a_acc), 8'h1);
    a_rst = 1'b1;
    step(); check("r_gnt", 8'(a_gnt), 8'h0); check("r_busy", 8'(a_busy), 8'h0);
    a_rst = 1'b0; a_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step(); check("r_no_late_gnt", 8'(a_gnt), 8'h0);
    end

    // a request present at the first edge after reset release is accepted;
    // pointer is 0 again, so requester 1 wins over 0
    a_rst = 1'b1; a_req = 2'b11;
    step(); check("rel_in_rst_acc", 8'(a_acc), 8'h0);
    a_rst = 1'b0;
    step(); check("rel_acc", 8'(a_acc), 8'h2);
    step(); check("rel_gnt", 8'(a_gnt), 8'h2);
    a_req = 2'b01;
    step(); check("rel_gap", 8'(a_gnt), 8'h0);
    a_req = 2'b00;
    step();

    // b: single-cycle pulse on req[0] with LAT=3 still gets a one-cycle grant
    b_req = 3'b001;
    step(); check("p_acc", 8'(b_acc), 8'h1);
    b_req = 3'b000;
    step(); check("p_k1_gnt", 8'(b_gnt), 8'h0);
    step(); check("p_k2_gnt", 8'(b_gnt), 8'h1);
    step(); check("p_k3_gap", 8'(b_gnt), 8'h0); check("p_k3_busy", 8'(b_busy), 8'h1);
    step(); check("p_k4_idle", 8'(b_busy), 8'h0);

    // b round-robin with wrap: pointer 0 -> 2 wins; pointer 2 -> wraps to 0
    b_owner(3'b101, 3'b100);
    b_owner(3'b101, 3'b001);
    b_owner(3'b110, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
